// File: rtl/pnr_discriminator_ctrl.sv
// Photon-number-resolving discriminator: peak capture, threshold classify, hold-off.
// Optional baseline subtraction enabled by defining PNR_BASELINE_EN.
module pnr_discriminator_ctrl #(
   parameter int DW    = 14,
   parameter int CW    = 16,
   parameter int EVT_W = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 enable_i,
   input  logic                 clear_i,
   input  logic                 trig_i,
   input  logic signed [DW-1:0] adc_dat_i,
   input  logic signed [DW-1:0] th1_i,
   input  logic signed [DW-1:0] th2_i,
   input  logic signed [DW-1:0] th3_i,
   input  logic signed [DW-1:0] th4_i,
   input  logic signed [DW-1:0] th5_i,
   input  logic signed [DW-1:0] th6_i,
   input  logic signed [DW-1:0] th7_i,
   input  logic [CW-1:0]        win_len_i,
   input  logic [CW-1:0]        holdoff_i,
   output logic                 busy_o,
   output logic                 pnr_valid_o,
   output logic [2:0]           pnr_num_o,
   output logic signed [DW-1:0] pnr_peak_o,
   output logic [EVT_W-1:0]     evt_cnt_o,
   output logic [15:0]          missed_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WIN,
      S_DEC,
      S_HOLD
   } state_t;

   localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};
   localparam logic signed [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};

   state_t                 state_q, state_d;
   logic                   trig_q;
   logic [CW-1:0]          win_q, win_d;
   logic [CW-1:0]          hold_q, hold_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic signed [DW-1:0]   peak_q, peak_d;
   logic                   valid_q, valid_d;
   logic [2:0]             num_q, num_d;
   logic signed [DW-1:0]   pk_q, pk_d;
   logic [EVT_W-1:0]       evt_q, evt_d;
   logic [15:0]            miss_q, miss_d;
   logic                   edge_w;
   logic                   start_w;
   logic signed [DW-1:0]   smp_w;
   logic signed [DW-1:0]   th_w [7];
   logic [2:0]             num_w;

   assign edge_w  = trig_i & ~trig_q;
   assign start_w = (state_q == S_IDLE) & edge_w & enable_i;

`ifdef PNR_BASELINE_EN
   logic signed [DW-1:0] base_q, base_d;
   logic signed [DW:0]   diff_w;

   assign diff_w = {adc_dat_i[DW-1], adc_dat_i} - {base_q[DW-1], base_q};

   // Overflow shows as disagreement between the two top bits.
   always_comb begin
      smp_w = diff_w[DW-1:0];
      if (diff_w[DW] != diff_w[DW-1])
         smp_w = diff_w[DW] ? MINV : MAXV;
   end

   always_comb begin
      base_d = base_q;
      if (start_w)
         base_d = adc_dat_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) base_q <= '0;
      else       base_q <= base_d;
   end
`else
   assign smp_w = adc_dat_i;
`endif

   assign th_w[0] = th1_i;
   assign th_w[1] = th2_i;
   assign th_w[2] = th3_i;
   assign th_w[3] = th4_i;
   assign th_w[4] = th5_i;
   assign th_w[5] = th6_i;
   assign th_w[6] = th7_i;

   always_comb begin
      num_w = '0;
      for (int i = 0; i < 7; i++)
         if (peak_q >= th_w[i])
            num_w = num_w + 3'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         trig_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         trig_q  <= trig_i;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (start_w) state_d = S_WIN;
         S_WIN: begin
            if (!enable_i)                   state_d = S_IDLE;
            else if (cnt_q == win_q - CW'(1)) state_d = S_DEC;
         end
         S_DEC: begin
            if (!enable_i || hold_q == '0) state_d = S_IDLE;
            else                           state_d = S_HOLD;
         end
         S_HOLD: begin
            if (!enable_i || cnt_q == hold_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      win_d   = win_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;
      peak_d  = peak_q;
      valid_d = 1'b0;
      num_d   = num_q;
      pk_d    = pk_q;
      evt_d   = evt_q;
      miss_d  = miss_q;
      if (start_w) begin
         win_d  = (win_len_i == '0) ? CW'(1) : win_len_i;
         hold_d = holdoff_i;
         peak_d = MINV;
         cnt_d  = '0;
      end
      if (state_q == S_WIN && enable_i) begin
         if (smp_w > peak_q) peak_d = smp_w;
         cnt_d = cnt_q + CW'(1);
      end
      // Hold-off counts from 1 so it lasts exactly hold_q cycles.
      if (state_q == S_DEC && enable_i) begin
         num_d   = num_w;
         pk_d    = peak_q;
         valid_d = 1'b1;
         evt_d   = evt_q + EVT_W'(1);
         cnt_d   = CW'(1);
      end
      if (state_q == S_HOLD)
         cnt_d = cnt_q + CW'(1);
      if (edge_w && state_q != S_IDLE && miss_q != 16'hFFFF)
         miss_d = miss_q + 16'd1;
      if (clear_i) begin
         evt_d  = '0;
         miss_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         win_q   <= '0;
         hold_q  <= '0;
         cnt_q   <= '0;
         peak_q  <= '0;
         valid_q <= 1'b0;
         num_q   <= '0;
         pk_q    <= '0;
         evt_q   <= '0;
         miss_q  <= '0;
      end else begin
         win_q   <= win_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
         peak_q  <= peak_d;
         valid_q <= valid_d;
         num_q   <= num_d;
         pk_q    <= pk_d;
         evt_q   <= evt_d;
         miss_q  <= miss_d;
      end
   end

   always_comb begin
      busy_o       = (state_q != S_IDLE);
      pnr_valid_o  = valid_q;
      pnr_num_o    = num_q;
      pnr_peak_o   = pk_q;
      evt_cnt_o    = evt_q;
      missed_cnt_o = miss_q;
   end

endmodule

// File: tb/tb_pnr_discriminator_ctrl.sv
// Directed self-checking bench for pnr_discriminator_ctrl.
// Extra baseline vectors run when PNR_BASELINE_EN is defined.
module tb_pnr_discriminator_ctrl;

   logic               clk = 1'b0;
   logic               rst, enable, clear, trig;
   logic signed [13:0] adc;
   logic signed [13:0] th [7];
   logic [15:0]        win_len, holdoff;
   logic               busy, valid;
   logic [2:0]         num;
   logic signed [13:0] peak;
   logic [31:0]        evt;
   logic [15:0]        missed;

   int checks = 0;
   int errors = 0;
   int vcnt;
   logic signed [13:0] sq [$];

   always #5 clk = ~clk;

   pnr_discriminator_ctrl dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .enable_i    (enable),
      .clear_i     (clear),
      .trig_i      (trig),
      .adc_dat_i   (adc),
      .th1_i       (th[0]),
      .th2_i       (th[1]),
      .th3_i       (th[2]),
      .th4_i       (th[3]),
      .th5_i       (th[4]),
      .th6_i       (th[5]),
      .th7_i       (th[6]),
      .win_len_i   (win_len),
      .holdoff_i   (holdoff),
      .busy_o      (busy),
      .pnr_valid_o (valid),
      .pnr_num_o   (num),
      .pnr_peak_o  (peak),
      .evt_cnt_o   (evt),
      .missed_cnt_o(missed)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Trigger in cycle T, feed sq over the window, stop in the valid cycle.
   task automatic fire(input logic signed [13:0] base, input logic clr);
      trig = 1'b1;
      adc  = base;
      tick();
      trig = 1'b0;
      foreach (sq[i]) begin
         adc = sq[i];
         tick();
      end
      chk("decide_no_valid", valid, 0);
      clear = clr;
      tick();
      clear = 1'b0;
      chk("valid_pulse", valid, 1);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; clear = 1'b0; trig = 1'b1; adc = '0;
      for (int i = 0; i < 7; i++) th[i] = 14'(100 * (i + 1));
      win_len = 16'd4; holdoff = 16'd0;
      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_valid", valid, 0);
      chk("rst_num", num, 0);
      chk("rst_peak", peak, 0);
      chk("rst_evt", evt, 0);
      chk("rst_missed", missed, 0);

      // Trigger held high across reset release is not an edge
      rst = 1'b0;
      tick();
      tick();
      chk("held_trig_busy", busy, 0);
      trig = 1'b0;
      tick();
      chk("held_trig_evt", evt, 0);

      // Basic measurement, W=4
      sq = '{50, 350, 120, 90};
      fire(0, 1'b0);
      chk("basic_num", num, 3);
      chk("basic_peak", peak, 350);
      chk("basic_evt", evt, 1);
      tick();
      chk("basic_pulse_end", valid, 0);
      chk("basic_idle", busy, 0);

      // Peak exactly at top threshold
      win_len = 16'd2;
      sq = '{0, 700};
      fire(0, 1'b0);
      chk("top_num", num, 7);
      chk("top_peak", peak, 700);

      // All samples at most negative value
      win_len = 16'd3;
      sq = '{-8192, -8192, -8192};
      fire(0, 1'b0);
      chk("neg_num", num, 0);
      chk("neg_peak", peak, -8192);
      chk("neg_evt", evt, 3);

      // Window length zero behaves as one sample, valid at T+3
      win_len = 16'd0;
      sq = '{250};
      fire(0, 1'b0);
      chk("w0_num", num, 2);
      chk("w0_peak", peak, 250);
      chk("w0_evt", evt, 4);

      // Missed triggers: W=10, H=5, edges at T+3, T+6, T+13; T+17 accepted
      win_len = 16'd10;
      holdoff = 16'd5;
      tick();
      trig = 1'b1;
      adc  = '0;
      tick();
      vcnt = 0;
      for (int c = 1; c <= 17; c++) begin
         trig = (c == 3 || c == 6 || c == 13 || c == 17);
         adc  = 14'(10 * c);
         if (valid) vcnt++;
         if (c == 12) begin
            chk("miss_valid_t12", valid, 1);
            chk("miss_num", num, 1);
            chk("miss_peak", peak, 100);
         end
         if (c == 16) chk("holdoff_last_busy", busy, 1);
         if (c == 17) chk("first_idle_busy", busy, 0);
         tick();
      end
      chk("miss_cnt", missed, 3);
      chk("miss_one_valid", vcnt, 1);
      chk("first_idle_accept", busy, 1);
      chk("miss_evt", evt, 5);

      // Disable during the window of the accepted trigger
      trig = 1'b0;
      enable = 1'b0;
      tick();
      chk("disable_idle", busy, 0);
      enable = 1'b1;
      holdoff = 16'd0;

      // Abort: enable low at T+2 of W=8
      win_len = 16'd8;
      tick();
      trig = 1'b1;
      adc  = '0;
      tick();
      trig = 1'b0;
      adc  = 14'd300;
      tick();
      enable = 1'b0;
      adc    = 14'd600;
      tick();
      chk("abort_busy", busy, 0);
      vcnt = 0;
      repeat (10) begin
         if (valid) vcnt++;
         tick();
      end
      chk("abort_no_valid", vcnt, 0);
      chk("abort_evt", evt, 5);
      chk("abort_num_kept", num, 1);
      enable = 1'b1;
      sq = '{10, 20, 450, 30, 40, 50, 60, 70};
      fire(0, 1'b0);
      chk("reenable_num", num, 4);
      chk("reenable_peak", peak, 450);
      chk("reenable_evt", evt, 6);

      // Reset in the middle of a window
      tick();
      trig = 1'b1;
      adc  = '0;
      tick();
      trig = 1'b0;
      adc  = 14'd5000;
      tick();
      rst = 1'b1;
      tick();
      chk("midrst_busy", busy, 0);
      chk("midrst_num", num, 0);
      chk("midrst_peak", peak, 0);
      chk("midrst_evt", evt, 0);
      chk("midrst_missed", missed, 0);
      rst = 1'b0;
      tick();

      // Clear coinciding with a valid wins over the increment
      fire(0, 1'b0);
      chk("pre_clear_evt", evt, 1);
      win_len = 16'd1;
      sq = '{650};
      fire(0, 1'b1);
      chk("clear_evt", evt, 0);
      chk("clear_num", num, 6);
      chk("clear_peak", peak, 650);

`ifdef PNR_BASELINE_EN
      win_len = 16'd3;
      sq = '{1100, 1350, 1200};
      fire(1000, 1'b0);
      chk("base_num", num, 3);
      chk("base_peak", peak, 350);
      win_len = 16'd1;
      sq = '{8191};
      fire(-8192, 1'b0);
      chk("base_sat_peak", peak, 8191);
      chk("base_sat_num", num, 7);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
